wr_req_demux_s4: RTL and testbench
==================================

# wr_req_demux_s4

Write-request demultiplexer for the interconnect: accepts the AXI3 write-address (AW) and write-data (W) channels from one master and routes each burst to one of four slaves by address decode. It tags the forwarded AWID/WID with the master number, so the per-master write-response mux can route B responses back by ID bits [3:2]. It allows one outstanding write burst per master port and holds a registered AW stage plus a W beat checker.

## Interface
Parameters:
- MASTER_ID, 2'd0, master number placed in slave-side ID bits [3:2]
- ADDR_W, 32, address width; slave selected by awaddr_m[ADDR_W-1:ADDR_W-2]

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- aclk  in  1  clock, all state updates on rising edge
- areset  in  1  synchronous active-high reset
- awid_m  in  2  master write ID
- awaddr_m  in  ADDR_W  write address
- awlen_m  in  4  beats-1
- awsize_m  in  3  beat size
- awburst_m  in  2  burst type
- awvalid_m / awready_m  in / out  1  AW handshake
- wid_m  in  2  write-data ID
- wdata_m  in  32  write data
- wstrb_m  in  4  byte strobes
- wlast_m  in  1  last beat
- wvalid_m / wready_m  in / out  1  W handshake
- awid_sN, awaddr_sN, awlen_sN, awsize_sN, awburst_sN, awvalid_sN  out  4/ADDR_W/4/3/2/1  AW to slave N (N=1..4)
- awready_sN  in  1
- wid_sN, wdata_sN, wstrb_sN, wlast_sN, wvalid_sN  out  4/32/4/1/1  W to slave N
- wready_sN  in  1
- wlast_err  out  1  sticky burst-length mismatch flag

## Operation
- States: IDLE, AW, DATA.
- IDLE: awready_m=1. On awvalid_m&awready_m:
  - capture awaddr/awlen/awsize/awburst
  - set captured ID = {MASTER_ID, awid_m}
  - set sel = awaddr_m[ADDR_W-1:ADDR_W-2] (00→s1, 01→s2, 10→s3, 11→s4)
  - go to AW.
- AW: awvalid_s[sel]=1 from the registers; the other slaves see awvalid=0. Stay until awready_s[sel]=1, then go to DATA and clear beat_cnt to 0.
- DATA: W is passed through combinationally to slave sel.
  - wvalid_s[sel]=wvalid_m and wready_m=wready_s[sel].
  - wid_s[sel]={MASTER_ID, wid_m}.
  - Non-selected slaves see wvalid=0.
  - On each W handshake, beat_cnt increments, wrapping mod 16.
  - A handshake with wlast_m=1 returns the FSM to IDLE.
- Outside DATA, wready_m=0 and all wvalid_sN=0. W beats that arrive early stall at the master.
- wlast_err is set on a W handshake where (wlast_m=1 and beat_cnt≠awlen) or (wlast_m=0 and beat_cnt==awlen). It stays set until areset. The burst still ends only on wlast_m.
- wid_m is not checked against awid_m; W routing follows the accepted AW.
- Slave data and address outputs may carry stale values while the matching valid is low.

## Timing
- While areset is high, and in the cycle after:
  - state=IDLE, awready_m=1, wready_m=0
  - all awvalid_sN=0 and wvalid_sN=0
  - wlast_err=0, beat_cnt=0, registers cleared.
- Reset mid-burst aborts the burst and the FSM returns to IDLE. Slaves may see a truncated burst; clearing that is a system-level reset concern.
- AW latency: master handshake in cycle T → awvalid_s[sel] high in T+1. Earliest slave AW handshake is T+1, earliest W beat is T+2.
- W adds zero latency: it is combinational, with a single-cycle wready/wvalid path.
- Next AW is accepted in the cycle after the wlast beat. Back-to-back single-beat bursts therefore take 3 cycles each.
- awvalid_s[sel] stays high and the AW registers stay stable until awready (AXI rule: no valid drop).
- awready_m does not depend on awvalid_m (no combinational loop).

## Structure
- Shared package/header ic_defs holds:
  - FSM state encodings (IDLE=2'd0, AW=2'd1, DATA=2'd2)
  - slave-select width 2 and the ID prefix position [3:2], shared with the response mux
  - AXI3 field widths.
- One sub-module, wr_addr_dec_s4: combinational decode of the upper 2 address bits into a one-hot 4-bit slave enable. Everything else stays in the top module.

## Test plan
- Reset, then AW to awaddr=0x4000_0000, awid=2'b01, awlen=0, MASTER_ID=2 → one cycle later awvalid_s2=1 and awid_s2=4'b1001. After the handshake, one W beat with wlast reaches s2 only; FSM returns to IDLE; wlast_err=0.
- awaddr=0xC000_0010, awlen=3, four beats with wready_s4 toggling → all 4 beats reach s4 in order and wready_m mirrors wready_s4; awready_m=0 until the cycle after beat 4.
- W presented before AW, or in the AW state with awready_s1 held low for 5 cycles → wready_m=0 and wvalid_s1=0 until DATA; awvalid_s1 stays high and stable for all 5 cycles.
- awlen=3 but wlast on beat 2 → burst ends and wlast_err=1 stays set. A following correct burst leaves it at 1; areset clears it.
- Reset asserted in DATA after 2 of 4 beats → next cycle IDLE, all valids 0, awready_m=1. A new AW is then accepted normally.
- Sweep all four address quadrants with awlen=15 → each slave receives 16 beats; no cross-slave valid is ever seen (asserted with a monitor).

Source files
------------

// File: rtl/ic_defs.sv
// Shared interconnect definitions: write-path FSM encoding, slave select and
// ID tagging layout (also used by the response mux), and AXI3 field widths.
package ic_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_DATA = 2'd2
    } wr_state_e;

    localparam int SEL_W   = 2;
    localparam int NUM_SLV = 4;

    // Master number sits in slave-side ID bits [3:2]; B responses route back on these.
    localparam int ID_PFX_HI = 3;
    localparam int ID_PFX_LO = 2;

    localparam int ID_M_W  = 2;
    localparam int ID_S_W  = 4;
    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;

    function automatic logic [ID_S_W-1:0] tag_id(
        input logic [ID_S_W-ID_M_W-1:0] pfx,
        input logic [ID_M_W-1:0]        id
    );
        return {pfx, id};
    endfunction

endpackage

// File: rtl/wr_addr_dec_s4.sv
// Combinational decode of the two address select bits into a one-hot
// four-slave enable.
module wr_addr_dec_s4
    import ic_defs::*;
(
    input  logic [SEL_W-1:0]   i_sel,
    output logic [NUM_SLV-1:0] o_en
);

    always_comb begin
        o_en        = '0;
        o_en[i_sel] = 1'b1;
    end

endmodule

// File: rtl/wr_req_demux_s4.sv
// AXI3 write-request demux: one outstanding burst, registered AW stage toward
// the decoded slave, combinational W pass-through with a burst-length checker.
module wr_req_demux_s4
    import ic_defs::*;
#(
    parameter logic [1:0] MASTER_ID = 2'd0,
    parameter int         ADDR_W    = 32
) (
    input  logic               aclk,
    input  logic               areset,

    input  logic [ID_M_W-1:0]  awid_m,
    input  logic [ADDR_W-1:0]  awaddr_m,
    input  logic [LEN_W-1:0]   awlen_m,
    input  logic [SIZE_W-1:0]  awsize_m,
    input  logic [BURST_W-1:0] awburst_m,
    input  logic               awvalid_m,
    output logic               awready_m,

    input  logic [ID_M_W-1:0]  wid_m,
    input  logic [DATA_W-1:0]  wdata_m,
    input  logic [STRB_W-1:0]  wstrb_m,
    input  logic               wlast_m,
    input  logic               wvalid_m,
    output logic               wready_m,

    output logic [ID_S_W-1:0]  awid_s1,
    output logic [ADDR_W-1:0]  awaddr_s1,
    output logic [LEN_W-1:0]   awlen_s1,
    output logic [SIZE_W-1:0]  awsize_s1,
    output logic [BURST_W-1:0] awburst_s1,
    output logic               awvalid_s1,
    input  logic               awready_s1,
    output logic [ID_S_W-1:0]  wid_s1,
    output logic [DATA_W-1:0]  wdata_s1,
    output logic [STRB_W-1:0]  wstrb_s1,
    output logic               wlast_s1,
    output logic               wvalid_s1,
    input  logic               wready_s1,

    output logic [ID_S_W-1:0]  awid_s2,
    output logic [ADDR_W-1:0]  awaddr_s2,
    output logic [LEN_W-1:0]   awlen_s2,
    output logic [SIZE_W-1:0]  awsize_s2,
    output logic [BURST_W-1:0] awburst_s2,
    output logic               awvalid_s2,
    input  logic               awready_s2,
    output logic [ID_S_W-1:0]  wid_s2,
    output logic [DATA_W-1:0]  wdata_s2,
    output logic [STRB_W-1:0]  wstrb_s2,
    output logic               wlast_s2,
    output logic               wvalid_s2,
    input  logic               wready_s2,

    output logic [ID_S_W-1:0]  awid_s3,
    output logic [ADDR_W-1:0]  awaddr_s3,
    output logic [LEN_W-1:0]   awlen_s3,
    output logic [SIZE_W-1:0]  awsize_s3,
    output logic [BURST_W-1:0] awburst_s3,
    output logic               awvalid_s3,
    input  logic               awready_s3,
    output logic [ID_S_W-1:0]  wid_s3,
    output logic [DATA_W-1:0]  wdata_s3,
    output logic [STRB_W-1:0]  wstrb_s3,
    output logic               wlast_s3,
    output logic               wvalid_s3,
    input  logic               wready_s3,

    output logic [ID_S_W-1:0]  awid_s4,
    output logic [ADDR_W-1:0]  awaddr_s4,
    output logic [LEN_W-1:0]   awlen_s4,
    output logic [SIZE_W-1:0]  awsize_s4,
    output logic [BURST_W-1:0] awburst_s4,
    output logic               awvalid_s4,
    input  logic               awready_s4,
    output logic [ID_S_W-1:0]  wid_s4,
    output logic [DATA_W-1:0]  wdata_s4,
    output logic [STRB_W-1:0]  wstrb_s4,
    output logic               wlast_s4,
    output logic               wvalid_s4,
    input  logic               wready_s4,

    output logic               wlast_err
);

    wr_state_e           r_state;
    wr_state_e           w_state_nxt;

    logic [ID_S_W-1:0]   r_awid;
    logic [ADDR_W-1:0]   r_awaddr;
    logic [LEN_W-1:0]    r_awlen;
    logic [SIZE_W-1:0]   r_awsize;
    logic [BURST_W-1:0]  r_awburst;
    logic [NUM_SLV-1:0]  r_sel;
    logic [LEN_W-1:0]    r_beat_cnt;
    logic                r_wlast_err;

    logic [NUM_SLV-1:0]  w_dec_en;
    logic [NUM_SLV-1:0]  w_awready_s;
    logic [NUM_SLV-1:0]  w_wready_s;
    logic                w_awready_sel;
    logic                w_wready_sel;
    logic                w_aw_hs_m;
    logic                w_aw_hs_s;
    logic                w_w_hs;
    logic                w_aw_vld;
    logic                w_w_vld;
    logic [ID_S_W-1:0]   w_wid_tag;

    wr_addr_dec_s4 u_dec (
        .i_sel (awaddr_m[ADDR_W-1 -: SEL_W]),
        .o_en  (w_dec_en)
    );

    assign w_awready_s   = {awready_s4, awready_s3, awready_s2, awready_s1};
    assign w_wready_s    = {wready_s4, wready_s3, wready_s2, wready_s1};
    assign w_awready_sel = |(w_awready_s & r_sel);
    assign w_wready_sel  = |(w_wready_s & r_sel);

    assign w_aw_hs_m = awvalid_m && (r_state == ST_IDLE) && !areset;
    assign w_aw_hs_s = w_aw_vld && w_awready_sel;
    assign w_w_hs    = wvalid_m && wready_m;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // awready_m is a function of state only; it also reads 1 throughout reset.
    always_comb begin
        w_state_nxt = r_state;
        awready_m   = 1'b0;
        wready_m    = 1'b0;
        w_aw_vld    = 1'b0;
        w_w_vld     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                awready_m = 1'b1;
                if (awvalid_m) begin
                    w_state_nxt = ST_AW;
                end
            end
            ST_AW: begin
                w_aw_vld = 1'b1;
                if (w_awready_sel) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                wready_m = w_wready_sel;
                w_w_vld  = wvalid_m;
                if (wvalid_m && w_wready_sel && wlast_m) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (areset) begin
            awready_m = 1'b1;
            wready_m  = 1'b0;
            w_aw_vld  = 1'b0;
            w_w_vld   = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_awid      <= '0;
            r_awaddr    <= '0;
            r_awlen     <= '0;
            r_awsize    <= '0;
            r_awburst   <= '0;
            r_sel       <= '0;
            r_beat_cnt  <= '0;
            r_wlast_err <= 1'b0;
        end else begin
            if (w_aw_hs_m) begin
                r_awid    <= tag_id(MASTER_ID, awid_m);
                r_awaddr  <= awaddr_m;
                r_awlen   <= awlen_m;
                r_awsize  <= awsize_m;
                r_awburst <= awburst_m;
                r_sel     <= w_dec_en;
            end
            if (w_aw_hs_s) begin
                r_beat_cnt <= '0;
            end else if (w_w_hs) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            // Sticky: flagged on either an early or a missing wlast; the burst still ends on wlast.
            if (w_w_hs && (wlast_m != (r_beat_cnt == r_awlen))) begin
                r_wlast_err <= 1'b1;
            end
        end
    end

    assign wlast_err = r_wlast_err;
    assign w_wid_tag = tag_id(MASTER_ID, wid_m);

    assign awid_s1    = r_awid;
    assign awaddr_s1  = r_awaddr;
    assign awlen_s1   = r_awlen;
    assign awsize_s1  = r_awsize;
    assign awburst_s1 = r_awburst;
    assign awvalid_s1 = w_aw_vld && r_sel[0];
    assign wid_s1     = w_wid_tag;
    assign wdata_s1   = wdata_m;
    assign wstrb_s1   = wstrb_m;
    assign wlast_s1   = wlast_m;
    assign wvalid_s1  = w_w_vld && r_sel[0];

    assign awid_s2    = r_awid;
    assign awaddr_s2  = r_awaddr;
    assign awlen_s2   = r_awlen;
    assign awsize_s2  = r_awsize;
    assign awburst_s2 = r_awburst;
    assign awvalid_s2 = w_aw_vld && r_sel[1];
    assign wid_s2     = w_wid_tag;
    assign wdata_s2   = wdata_m;
    assign wstrb_s2   = wstrb_m;
    assign wlast_s2   = wlast_m;
    assign wvalid_s2  = w_w_vld && r_sel[1];

    assign awid_s3    = r_awid;
    assign awaddr_s3  = r_awaddr;
    assign awlen_s3   = r_awlen;
    assign awsize_s3  = r_awsize;
    assign awburst_s3 = r_awburst;
    assign awvalid_s3 = w_aw_vld && r_sel[2];
    assign wid_s3     = w_wid_tag;
    assign wdata_s3   = wdata_m;
    assign wstrb_s3   = wstrb_m;
    assign wlast_s3   = wlast_m;
    assign wvalid_s3  = w_w_vld && r_sel[2];

    assign awid_s4    = r_awid;
    assign awaddr_s4  = r_awaddr;
    assign awlen_s4   = r_awlen;
    assign awsize_s4  = r_awsize;
    assign awburst_s4 = r_awburst;
    assign awvalid_s4 = w_aw_vld && r_sel[3];
    assign wid_s4     = w_wid_tag;
    assign wdata_s4   = wdata_m;
    assign wstrb_s4   = wstrb_m;
    assign wlast_s4   = wlast_m;
    assign wvalid_s4  = w_w_vld && r_sel[3];

endmodule

// File: tb/tb_wr_req_demux_s4.sv
// Directed bench for wr_req_demux_s4: table of bursts plus hand sequences for
// reset mid-burst and an all-quadrant sweep, with a cross-slave valid monitor.
module tb_wr_req_demux_s4;

    logic        aclk = 1'b0;
    logic        areset;
    logic [1:0]  awid_m;
    logic [31:0] awaddr_m;
    logic [3:0]  awlen_m;
    logic [2:0]  awsize_m;
    logic [1:0]  awburst_m;
    logic        awvalid_m;
    logic        awready_m;
    logic [1:0]  wid_m;
    logic [31:0] wdata_m;
    logic [3:0]  wstrb_m;
    logic        wlast_m;
    logic        wvalid_m;
    logic        wready_m;
    logic        wlast_err;

    logic [3:0]  awid_s1, awid_s2, awid_s3, awid_s4;
    logic [31:0] awaddr_s1, awaddr_s2, awaddr_s3, awaddr_s4;
    logic [3:0]  awlen_s1, awlen_s2, awlen_s3, awlen_s4;
    logic [2:0]  awsize_s1, awsize_s2, awsize_s3, awsize_s4;
    logic [1:0]  awburst_s1, awburst_s2, awburst_s3, awburst_s4;
    logic        awvalid_s1, awvalid_s2, awvalid_s3, awvalid_s4;
    logic [3:0]  wid_s1, wid_s2, wid_s3, wid_s4;
    logic [31:0] wdata_s1, wdata_s2, wdata_s3, wdata_s4;
    logic [3:0]  wstrb_s1, wstrb_s2, wstrb_s3, wstrb_s4;
    logic        wlast_s1, wlast_s2, wlast_s3, wlast_s4;
    logic        wvalid_s1, wvalid_s2, wvalid_s3, wvalid_s4;
    logic [3:0]  awready_s;
    logic [3:0]  wready_s;

    logic [3:0]  awvalid_s, wvalid_s;
    logic [3:0]  awid_sa [4];
    logic [31:0] awaddr_sa [4];
    logic [3:0]  awlen_sa [4];
    logic [3:0]  wid_sa [4];
    logic [31:0] wdata_sa [4];
    logic        wlast_sa [4];

    assign awvalid_s = {awvalid_s4, awvalid_s3, awvalid_s2, awvalid_s1};
    assign wvalid_s  = {wvalid_s4, wvalid_s3, wvalid_s2, wvalid_s1};
    assign awid_sa[0] = awid_s1;   assign awid_sa[1] = awid_s2;
    assign awid_sa[2] = awid_s3;   assign awid_sa[3] = awid_s4;
    assign awaddr_sa[0] = awaddr_s1; assign awaddr_sa[1] = awaddr_s2;
    assign awaddr_sa[2] = awaddr_s3; assign awaddr_sa[3] = awaddr_s4;
    assign awlen_sa[0] = awlen_s1; assign awlen_sa[1] = awlen_s2;
    assign awlen_sa[2] = awlen_s3; assign awlen_sa[3] = awlen_s4;
    assign wid_sa[0] = wid_s1;     assign wid_sa[1] = wid_s2;
    assign wid_sa[2] = wid_s3;     assign wid_sa[3] = wid_s4;
    assign wdata_sa[0] = wdata_s1; assign wdata_sa[1] = wdata_s2;
    assign wdata_sa[2] = wdata_s3; assign wdata_sa[3] = wdata_s4;
    assign wlast_sa[0] = wlast_s1; assign wlast_sa[1] = wlast_s2;
    assign wlast_sa[2] = wlast_s3; assign wlast_sa[3] = wlast_s4;

    wr_req_demux_s4 #(.MASTER_ID(2'd2), .ADDR_W(32)) dut (
        .aclk(aclk), .areset(areset),
        .awid_m(awid_m), .awaddr_m(awaddr_m), .awlen_m(awlen_m), .awsize_m(awsize_m),
        .awburst_m(awburst_m), .awvalid_m(awvalid_m), .awready_m(awready_m),
        .wid_m(wid_m), .wdata_m(wdata_m), .wstrb_m(wstrb_m), .wlast_m(wlast_m),
        .wvalid_m(wvalid_m), .wready_m(wready_m),
        .awid_s1(awid_s1), .awaddr_s1(awaddr_s1), .awlen_s1(awlen_s1), .awsize_s1(awsize_s1),
        .awburst_s1(awburst_s1), .awvalid_s1(awvalid_s1), .awready_s1(awready_s[0]),
        .wid_s1(wid_s1), .wdata_s1(wdata_s1), .wstrb_s1(wstrb_s1), .wlast_s1(wlast_s1),
        .wvalid_s1(wvalid_s1), .wready_s1(wready_s[0]),
        .awid_s2(awid_s2), .awaddr_s2(awaddr_s2), .awlen_s2(awlen_s2), .awsize_s2(awsize_s2),
        .awburst_s2(awburst_s2), .awvalid_s2(awvalid_s2), .awready_s2(awready_s[1]),
        .wid_s2(wid_s2), .wdata_s2(wdata_s2), .wstrb_s2(wstrb_s2), .wlast_s2(wlast_s2),
        .wvalid_s2(wvalid_s2), .wready_s2(wready_s[1]),
        .awid_s3(awid_s3), .awaddr_s3(awaddr_s3), .awlen_s3(awlen_s3), .awsize_s3(awsize_s3),
        .awburst_s3(awburst_s3), .awvalid_s3(awvalid_s3), .awready_s3(awready_s[2]),
        .wid_s3(wid_s3), .wdata_s3(wdata_s3), .wstrb_s3(wstrb_s3), .wlast_s3(wlast_s3),
        .wvalid_s3(wvalid_s3), .wready_s3(wready_s[2]),
        .awid_s4(awid_s4), .awaddr_s4(awaddr_s4), .awlen_s4(awlen_s4), .awsize_s4(awsize_s4),
        .awburst_s4(awburst_s4), .awvalid_s4(awvalid_s4), .awready_s4(awready_s[3]),
        .wid_s4(wid_s4), .wdata_s4(wdata_s4), .wstrb_s4(wstrb_s4), .wlast_s4(wlast_s4),
        .wvalid_s4(wvalid_s4), .wready_s4(wready_s[3]),
        .wlast_err(wlast_err)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;
    int mon_viol = 0;
    int cur_s = 0;
    logic [3:0] exp_mask = 4'b0000;

    // Any valid toward a slave other than the current burst target is a routing error.
    always @(negedge aclk) begin
        #2;
        if (((awvalid_s & ~exp_mask) != 4'b0) || ((wvalid_s & ~exp_mask) != 4'b0))
            mon_viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_awready_m"}, awready_m, 1'b1);
        chk({tag, "_wready_m"}, wready_m, 1'b0);
        chk({tag, "_awvalid_s"}, awvalid_s, 4'b0);
        chk({tag, "_wvalid_s"}, wvalid_s, 4'b0);
    endtask

    // Master AW handshake with an early W beat pending, then AW to the slave with optional stall.
    task automatic do_aw(input logic [31:0] addr, input logic [1:0] id, input logic [3:0] len,
                         input int stall, input logic [31:0] first_data);
        cur_s = int'(addr[31:30]);
        exp_mask = 4'b0001 << cur_s;
        awvalid_m = 1'b1; awaddr_m = addr; awid_m = id; awlen_m = len;
        awsize_m = 3'd2; awburst_m = 2'd1;
        wvalid_m = 1'b1; wid_m = id; wdata_m = first_data; wlast_m = 1'b0;
        #1;
        chk("aw_ready_idle", awready_m, 1'b1);
        chk("w_ready_before_aw", wready_m, 1'b0);
        chk("w_valid_before_aw", wvalid_s, 4'b0);
        @(posedge aclk); @(negedge aclk);
        awvalid_m = 1'b0; awaddr_m = 32'hFFFF_FFFF; awid_m = ~id; awlen_m = ~len;
        #1;
        chk("awvalid_s_T1", awvalid_s, exp_mask);
        chk("awid_s_tag", awid_sa[cur_s], {2'b10, id});
        chk("awaddr_s", awaddr_sa[cur_s], addr);
        chk("awlen_s", awlen_sa[cur_s], len);
        for (int i = 0; i < stall; i++) begin
            @(posedge aclk); @(negedge aclk); #1;
            chk("awvalid_hold", awvalid_s, exp_mask);
            chk("awaddr_stable", awaddr_sa[cur_s], addr);
            chk("w_ready_in_aw", wready_m, 1'b0);
            chk("w_valid_in_aw", wvalid_s, 4'b0);
            chk("aw_ready_busy", awready_m, 1'b0);
        end
        awready_s = exp_mask;
        @(posedge aclk); @(negedge aclk);
        awready_s = 4'b0;
    endtask

    // Drive nbeats W beats; wlast on the final one only when end_last is set.
    task automatic do_beats(input int nbeats, input bit end_last, input bit toggle,
                            input logic [31:0] base, input logic [1:0] id);
        int b;
        int cyc;
        bit hs;
        b = 0;
        cyc = 0;
        while (b < nbeats && cyc < 200) begin
            wvalid_m = 1'b1; wid_m = id; wdata_m = base + b;
            wlast_m = end_last && (b == nbeats - 1);
            wready_s = (toggle && (cyc % 2 == 0)) ? 4'b0 : exp_mask;
            #1;
            chk("w_ready_mirror", wready_m, (wready_s != 4'b0));
            chk("w_valid_route", wvalid_s, exp_mask);
            chk("aw_ready_in_data", awready_m, 1'b0);
            hs = (wready_s != 4'b0);
            if (hs) begin
                chk("wdata_s", wdata_sa[cur_s], base + b);
                chk("wid_s_tag", wid_sa[cur_s], {2'b10, id});
                chk("wlast_s", wlast_sa[cur_s], end_last && (b == nbeats - 1));
            end
            @(posedge aclk); @(negedge aclk);
            if (hs) b++;
            cyc++;
        end
        wvalid_m = 1'b0; wlast_m = 1'b0; wready_s = 4'b0;
        chk("beats_delivered", b, nbeats);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  id;
        logic [3:0]  len;
        int          nbeats;
        bit          toggle;
        int          stall;
        bit          exp_err;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{32'h4000_0000, 2'b01, 4'd0, 1, 1'b0, 0, 1'b0};
        vecs[1] = '{32'hC000_0010, 2'b10, 4'd3, 4, 1'b1, 0, 1'b0};
        vecs[2] = '{32'h0000_0100, 2'b00, 4'd1, 2, 1'b0, 5, 1'b0};
        vecs[3] = '{32'h8000_0000, 2'b11, 4'd3, 2, 1'b0, 0, 1'b1};
        vecs[4] = '{32'h0000_0040, 2'b01, 4'd0, 1, 1'b0, 0, 1'b1};

        areset = 1'b1;
        awid_m = '0; awaddr_m = '0; awlen_m = '0; awsize_m = '0; awburst_m = '0;
        awvalid_m = 1'b0; wid_m = '0; wdata_m = '0; wstrb_m = 4'hF; wlast_m = 1'b0;
        wvalid_m = 1'b0; awready_s = 4'b0; wready_s = 4'b0;

        repeat (2) @(posedge aclk);
        @(negedge aclk); #1;
        chk_idle_outputs("in_reset");
        chk("in_reset_err", wlast_err, 1'b0);
        areset = 1'b0;
        @(posedge aclk); @(negedge aclk); #1;
        chk_idle_outputs("post_reset");
        chk("post_reset_err", wlast_err, 1'b0);

        for (int v = 0; v < 5; v++) begin
            logic [31:0] base;
            base = 32'hA500_0000 + (v << 8);
            do_aw(vecs[v].addr, vecs[v].id, vecs[v].len, vecs[v].stall, base);
            do_beats(vecs[v].nbeats, 1'b1, vecs[v].toggle, base, vecs[v].id);
            #1;
            chk("burst_end_idle", awready_m, 1'b1);
            chk("burst_end_wvalid", wvalid_s, 4'b0);
            chk("wlast_err_after_burst", wlast_err, vecs[v].exp_err);
        end

        // Reset two beats into a four-beat burst.
        do_aw(32'h4000_0020, 2'b10, 4'd3, 0, 32'h5500_0000);
        do_beats(2, 1'b0, 1'b0, 32'h5500_0000, 2'b10);
        wvalid_m = 1'b1; wready_s = exp_mask;
        #1;
        chk("mid_burst_still_data", awready_m, 1'b0);
        areset = 1'b1;
        #1;
        chk_idle_outputs("reset_mid_burst");
        @(posedge aclk); @(negedge aclk);
        areset = 1'b0; wvalid_m = 1'b0; wready_s = 4'b0;
        #1;
        chk_idle_outputs("after_mid_reset");
        chk("err_cleared_by_reset", wlast_err, 1'b0);

        // All quadrants, 16-beat bursts, starting straight after the aborted one.
        for (int q = 0; q < 4; q++) begin
            logic [31:0] a;
            logic [31:0] base;
            a = (32'(q) << 30) | 32'h0000_1000;
            base = 32'h3C00_0000 + (q << 12);
            do_aw(a, 2'(q), 4'd15, 0, base);
            do_beats(16, 1'b1, (q % 2 == 1), base, 2'(q));
            #1;
            chk("sweep_idle", awready_m, 1'b1);
            chk("sweep_err", wlast_err, 1'b0);
        end

        exp_mask = 4'b0000;
        repeat (2) @(posedge aclk);
        @(negedge aclk); #3;
        chk("cross_slave_valid_events", mon_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
